cpu_mem_arbiter: RTL
====================

Name: cpu_mem_arbiter

Overview:
Shares one single-port 64-bit on-chip memory between three requesters: CPU instruction fetch (imem), CPU data (dmem) and a host loader port (PS side, same clock domain after CDC).
- One transaction is in flight at a time, sequenced by a small FSM.
- Priority is host > dmem > imem, with a starvation guard that promotes imem over dmem.
- Sits between cpu_top's memory interfaces and the memory macro.

Parameters:
ADDR_WIDTH, 32, byte-address width of all requester ports
DATA_WIDTH, 64, memory word width (fixed 64; byte enables are 8 bits)
INST_WIDTH, 32, instruction width returned on imem port
MEM_DEPTH, 4096, memory depth in 64-bit words (32KB)
MEM_LAT, 1, memory read latency in cycles (1..4)
STARVE_LIMIT, 8, cycles imem may wait before beating dmem

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
imem_addr  in  ADDR_WIDTH  fetch byte address
imem_read  in  1  fetch request (level, held until imem_ready)
imem_read_data  out  INST_WIDTH  instruction, valid with imem_ready
imem_ready  out  1  one-cycle completion pulse
dmem_addr  in  ADDR_WIDTH  data byte address
dmem_write_data  in  DATA_WIDTH  store data
dmem_read  in  1  load request (level)
dmem_write  in  1  store request (level)
dmem_byte_enable  in  8  store byte lanes
dmem_read_data  out  DATA_WIDTH  load data, valid with dmem_ready
dmem_ready  out  1  one-cycle completion pulse
host_req  in  1  host request (level)
host_we  in  1  host write
host_addr  in  ADDR_WIDTH  host byte address
host_wdata  in  DATA_WIDTH  host write data
host_be  in  8  host byte lanes
host_rdata  out  DATA_WIDTH  host read data
host_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  8  per-byte write enables (0 = read)
mem_addr  out  $clog2(MEM_DEPTH)  word address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, MEM_LAT cycles after mem_en
access_err  out  1  one-cycle pulse: completed transaction was out of range
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0; FSM IDLE; starvation counter 0; data output registers 0.
- FSM IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
- IDLE: arbitrate among asserted requests.
  - Winner's address, data, enables and id are latched; go to ISSUE.
  - Priority: host, then dmem, then imem.
  - Exception: if starve_cnt == STARVE_LIMIT, imem beats dmem but not host.
- ISSUE: mem_en=1 for exactly one cycle; mem_addr = addr[ADDR_WIDTH-1:3] truncated to the memory address width.
  - Write: mem_we=be, then go to RESP.
  - Read: mem_we=0, then go to WAIT.
- WAIT: count MEM_LAT cycles, capture mem_rdata on the last one, then go to RESP.
- RESP: pulse the winner's ready/ack for one cycle with data; return to IDLE.
  - Read latency from request sampled in IDLE (cycle 0) to ready: MEM_LAT+2 cycles.
  - Write latency: 2 cycles.
- No back-to-back issue; arbitration happens only in IDLE.
- imem data: addr[2]=0 returns rdata[31:0]; addr[2]=1 returns rdata[63:32]. imem never writes.
- dmem_read && dmem_write both high: treated as a write.
- Out of range (addr[ADDR_WIDTH-1:3] >= MEM_DEPTH): mem_en suppressed.
  - ready/ack still pulses in RESP, read data 0, access_err pulses with it.
  - Latency is unchanged.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each IDLE-arbitration cycle imem_read is high and not granted.
  - Clears when imem is granted or imem_read is low in IDLE.
- Request dropped mid-transaction: the transaction completes and ready still pulses; the requester ignores it.
- Reset mid-transaction: FSM returns to IDLE immediately and no ready pulse is produced. A write already in ISSUE may have reached memory.
- Output data registers hold their value between pulses.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs stat_imem, stat_dmem, stat_host (32 bits each) counting grants, wrapping at 2^32, cleared by rst. Also adds stat_starve (32 bits), counting grants given by starvation override.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
Package cpu_mem_arb_pkg holds:
- enum arb_state_e {IDLE, ISSUE, WAIT, RESP}
- enum req_id_e {REQ_NONE, REQ_IMEM, REQ_DMEM, REQ_HOST}
- function word_index(addr) and constant BE_W=8

Sub-module cpu_mem_arb_prio: combinational priority plus the starve_cnt register. Outputs req_id_e grant, with a grant_take input from the FSM.

Test Plan:
- Reset-release values:
  - Assert rst mid-READ (FSM in WAIT) -> busy=0 next cycle, no imem_ready/dmem_ready/host_ack pulse.
  - All outputs 0 during rst.
- imem fetch:
  - Preload word 0x10 = 0xAAAA5555_12345678; imem_read with addr 0x84 -> imem_ready at cycle MEM_LAT+2, data 0xAAAA5555.
  - addr 0x80 -> 0x12345678.
- dmem store:
  - Store 0x1122334455667788, be=0x0F, at addr 0x100 over 0xFFFF... -> dmem_ready after 2 cycles.
  - Readback 0xFFFFFFFF55667788.
- Contention: host, dmem and imem all high at cycle 0 -> grant order host, dmem, imem; exactly one ready pulse per transaction.
- Starvation (STARVE_LIMIT=8):
  - dmem_read held continuously and imem_read held -> imem granted at the first arbitration after 8 losses; stat_starve=1 when ARB_STATS_EN.
- Out of range: dmem_read addr = MEM_DEPTH*8 -> mem_en stays 0, dmem_ready and access_err pulse together, dmem_read_data=0.

Source files
------------

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and helpers for the CPU/host single-port memory arbiter.
// Optional grant statistics are enabled by defining ARB_STATS_EN.
package cpu_mem_arb_pkg;

    localparam int BE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_IMEM,
        REQ_DMEM,
        REQ_HOST
    } req_id_e;

    // Byte address to 64-bit word index; callers slice it to the memory width.
    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return addr >> 3;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Requester and memory-side bus of cpu_mem_arbiter; slave = arbiter view,
// master = requesters plus memory macro view.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096
);
    import cpu_mem_arb_pkg::*;

    localparam int MEM_AW = $clog2(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_read;
    logic [INST_WIDTH-1:0] imem_read_data;
    logic                  imem_ready;

    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_write_data;
    logic                  dmem_read;
    logic                  dmem_write;
    logic [BE_W-1:0]       dmem_byte_enable;
    logic [DATA_WIDTH-1:0] dmem_read_data;
    logic                  dmem_ready;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic [BE_W-1:0]       host_be;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_ack;

    logic                  mem_en;
    logic [BE_W-1:0]       mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  access_err;
    logic                  busy;

    modport slave (
        input  imem_addr, imem_read,
        output imem_read_data, imem_ready,
        input  dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable,
        output dmem_read_data, dmem_ready,
        input  host_req, host_we, host_addr, host_wdata, host_be,
        output host_rdata, host_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output access_err, busy
    );

    modport master (
        output imem_addr, imem_read,
        input  imem_read_data, imem_ready,
        output dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable,
        input  dmem_read_data, dmem_ready,
        output host_req, host_we, host_addr, host_wdata, host_be,
        input  host_rdata, host_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  access_err, busy
    );

endinterface

// File: rtl/cpu_mem_arb_prio.sv
// Fixed-priority grant (host > dmem > imem) with an imem starvation counter.
// With ARB_STATS_EN defined it also flags grants won by starvation override.
module cpu_mem_arb_prio
    import cpu_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    imem_req,
    input  logic    dmem_req,
    input  logic    host_req,
    input  logic    grant_take,
`ifdef ARB_STATS_EN
    output logic    starve_win,
`endif
    output req_id_e grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // A starved fetch jumps ahead of data accesses but never ahead of the host.
    always_comb begin
        grant = REQ_NONE;
        if (host_req) begin
            grant = REQ_HOST;
        end else if (imem_req && starved) begin
            grant = REQ_IMEM;
        end else if (dmem_req) begin
            grant = REQ_DMEM;
        end else if (imem_req) begin
            grant = REQ_IMEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_take) begin
            if (!imem_req || grant == REQ_IMEM) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    assign starve_win = starved && imem_req && dmem_req && !host_req;
`endif

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port 64-bit memory between imem, dmem and host, one access at a time.
// Define ARB_STATS_EN to add the stat_imem/stat_dmem/stat_host/stat_starve grant counters.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int MEM_DEPTH    = 4096,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ARB_STATS_EN
    output logic [31:0] stat_imem,
    output logic [31:0] stat_dmem,
    output logic [31:0] stat_host,
    output logic [31:0] stat_starve,
`endif
    cpu_mem_arbiter_if.slave bus
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);

    arb_state_e state, next_state;
    req_id_e    grant, id_q;
    logic       grant_take, dmem_req, wait_done;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_W-1:0]       sel_be;
    logic                  sel_we;
    logic [63:0]           sel_widx;
    logic                  sel_oor;

    logic                  we_q, hi_q, oor_q;
    logic [BE_W-1:0]       be_q;
    logic [MEM_AW-1:0]     widx_q;
    logic [DATA_WIDTH-1:0] wdata_q, cap_data;
    logic [2:0]            lat_cnt;

`ifdef ARB_STATS_EN
    logic starve_win;
`endif

    assign dmem_req = bus.dmem_read | bus.dmem_write;

    cpu_mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (bus.imem_read),
        .dmem_req   (dmem_req),
        .host_req   (bus.host_req),
        .grant_take (grant_take),
`ifdef ARB_STATS_EN
        .starve_win (starve_win),
`endif
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant != REQ_NONE) next_state = ISSUE;
            ISSUE:   next_state = we_q ? RESP : WAIT;
            WAIT:    if (wait_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Out-of-range accesses walk the same states so latency is unchanged; only the strobe is hidden.
    always_comb begin
        bus.mem_en     = 1'b0;
        bus.mem_we     = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.host_ack   = 1'b0;
        bus.access_err = 1'b0;
        bus.busy       = (state != IDLE);
        grant_take     = (state == IDLE);
        case (state)
            ISSUE: begin
                bus.mem_en = !oor_q;
                if (we_q && !oor_q) bus.mem_we = be_q;
            end
            RESP: begin
                bus.imem_ready = (id_q == REQ_IMEM);
                bus.dmem_ready = (id_q == REQ_DMEM);
                bus.host_ack   = (id_q == REQ_HOST);
                bus.access_err = oor_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = widx_q;
    assign bus.mem_wdata = wdata_q;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_we    = 1'b0;
        case (grant)
            REQ_HOST: begin
                sel_addr  = bus.host_addr;
                sel_wdata = bus.host_wdata;
                sel_be    = bus.host_be;
                sel_we    = bus.host_we;
            end
            REQ_DMEM: begin
                sel_addr  = bus.dmem_addr;
                sel_wdata = bus.dmem_write_data;
                sel_be    = bus.dmem_byte_enable;
                sel_we    = bus.dmem_write;
            end
            REQ_IMEM: sel_addr = bus.imem_addr;
            default: ;
        endcase
        sel_widx = word_index(64'(sel_addr));
        sel_oor  = (sel_widx >= 64'(MEM_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= REQ_NONE;
            we_q    <= 1'b0;
            hi_q    <= 1'b0;
            oor_q   <= 1'b0;
            be_q    <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && grant != REQ_NONE) begin
            id_q    <= grant;
            we_q    <= sel_we;
            hi_q    <= sel_addr[2];
            oor_q   <= sel_oor;
            be_q    <= sel_be;
            widx_q  <= sel_widx[MEM_AW-1:0];
            wdata_q <= sel_wdata;
        end
    end

    assign wait_done = (lat_cnt == 3'(MEM_LAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == ISSUE) begin
            lat_cnt <= '0;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
        end
    end

    assign cap_data = oor_q ? '0 : bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.imem_read_data <= '0;
            bus.dmem_read_data <= '0;
            bus.host_rdata     <= '0;
        end else if (state == WAIT && wait_done) begin
            case (id_q)
                REQ_IMEM: bus.imem_read_data <= hi_q ? cap_data[2*INST_WIDTH-1:INST_WIDTH]
                                                     : cap_data[INST_WIDTH-1:0];
                REQ_DMEM: bus.dmem_read_data <= cap_data;
                REQ_HOST: bus.host_rdata     <= cap_data;
                default: ;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_imem   <= '0;
            stat_dmem   <= '0;
            stat_host   <= '0;
            stat_starve <= '0;
        end else if (grant_take) begin
            case (grant)
                REQ_IMEM: stat_imem <= stat_imem + 32'd1;
                REQ_DMEM: stat_dmem <= stat_dmem + 32'd1;
                REQ_HOST: stat_host <= stat_host + 32'd1;
                default: ;
            endcase
            if (starve_win) stat_starve <= stat_starve + 32'd1;
        end
    end
`endif

endmodule
